led_band_reader: RTL and testbench
==================================

LED_BAND_READER -- requirements
Module: led_band_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, byte address width of the LED band memory read port.
REQ-002 Parameter DATA_WIDTH, default 8, byte width of the memory read port and output stream.
REQ-003 Parameter LEN_WIDTH, default 15, width of the burst length field.
REQ-004 clk  in  1  single clock; all logic on posedge clk; the memory read port shares this clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  burst request; sampled only in IDLE.
REQ-007 start_addr  in  ADDR_WIDTH  first byte address of the burst.
REQ-008 len  in  LEN_WIDTH  number of bytes in the burst; 0 is legal.
REQ-009 busy  out  1  high from the cycle after start is accepted until the cycle done is high, inclusive.
REQ-010 done  out  1  one-cycle pulse: burst complete.
REQ-011 mem_read  out  1  read enable to the memory read port.
REQ-012 mem_addr  out  ADDR_WIDTH  byte address to the memory read port.
REQ-013 mem_data  in  DATA_WIDTH  memory read data, valid exactly one cycle after mem_read.
REQ-014 out_data  out  DATA_WIDTH  streamed byte.
REQ-015 out_valid  out  1  out_data valid.
REQ-016 out_ready  in  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high.

Function
REQ-017 FSM states IDLE, READ, DRAIN; reset state IDLE.
REQ-018 IDLE: start=1 latches start_addr and len; len>0 goes to READ, len=0 goes to DRAIN (no memory read issued).
REQ-019 READ: issues one read per cycle while credit allows; mem_addr starts at start_addr and increments by 1 per issued read, wrapping modulo 2^ADDR_WIDTH.
REQ-020 Credit rule: a read is issued only when fifo_count + inflight < 4, using registered values; the pop in the same cycle is not credited.
REQ-021 After issuing len reads, READ goes to DRAIN.
REQ-022 DRAIN: waits until the FIFO is empty and no read is in flight, then pulses done for one cycle and returns to IDLE.
REQ-023 mem_data is pushed into a 4-entry FIFO on the cycle after each mem_read; the FIFO never overflows under REQ-020.
REQ-024 out_valid = FIFO non-empty; out_data = FIFO head; both registered, with no combinational path from out_ready to out_valid or out_data.
REQ-025 out_data holds stable while out_valid=1 and out_ready=0.
REQ-026 Latency: start accepted at cycle t -> mem_read at t+1 -> first out_valid at t+3.
REQ-027 Throughput: with out_ready held high, sustains one byte per cycle after the first byte.
REQ-028 Bytes are emitted in strictly increasing address order (modulo wrap) and exactly len bytes are emitted per burst.
REQ-029 start while busy is ignored, with no effect on the current burst.
REQ-030 mem_addr holds its last value when mem_read=0.
REQ-031 Counters are LEN_WIDTH+1 bits wide, so len = 2^LEN_WIDTH-1 completes without overflow.

Reset
REQ-032 On rst=1 at a clock edge: state IDLE, FIFO empty, inflight=0, counters 0.
REQ-033 Output reset values: busy=0, done=0, mem_read=0, mem_addr=0, out_valid=0, out_data=0.
REQ-034 Reset mid-burst aborts the burst: no done pulse, and read data returning in the cycle after reset is discarded.

Structure
REQ-035 Shared package led_band_pkg holds the ADDR/DATA/LEN width constants and the reader state enum.
REQ-036 The FIFO is a sub-module led_byte_fifo: 4 entries, DATA_WIDTH wide, synchronous, with push, pop, count, and registered head.
REQ-037 Credit and address counters reside in led_band_reader.

Verification
REQ-038 start_addr=0x0010, len=4, out_ready=1 -> mem_addr 0x10..0x13 on consecutive cycles; bytes emitted in order, first at t+3; done pulses once.
REQ-039 len=0 -> mem_read never asserted, out_valid never asserted, done within 2 cycles, busy drops with done.
REQ-040 start_addr=0x7FFE, len=4 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001, with data matching.
REQ-041 len=16, out_ready toggling 1-0-0-1 random -> all 16 bytes emitted exactly once, no FIFO overflow, out_data stable while stalled.
REQ-042 rst asserted at the 3rd byte of a len=10 burst -> all outputs at reset values next cycle, no done pulse, and a new burst then runs correctly.
REQ-043 start re-asserted during a busy burst -> ignored; only the original len bytes are emitted.

Source files
------------

// File: rtl/led_band_pkg.sv
// Shared widths, FIFO sizing and reader state encoding for the LED band reader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package led_band_pkg;

    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 8;
    localparam int LEN_W      = 15;
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CNT_W = 3;   // holds 0..FIFO_DEPTH inclusive

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/led_byte_fifo.sv
// Purpose: 4-entry synchronous byte FIFO buffering memory read data for the output stream.
// Latency: a push is visible at head/count on the cycle after the push edge.
// Backpressure: none internally; the caller guarantees no push when full (overflow-guarded anyway).
// Ports: clk/rst (sync, active-high); push + push_data write; pop removes head;
//        count = occupancy (0..4); head = oldest entry, driven only from registers.
module led_byte_fifo
    import led_band_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [FIFO_CNT_W-1:0] count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [1:0]            wr_ptr_q;
    logic [1:0]            rd_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign push_ok = push && (count_q != FIFO_CNT_W'(FIFO_DEPTH));
    assign pop_ok  = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + {{(FIFO_CNT_W-1){1'b0}}, push_ok}
                               - {{(FIFO_CNT_W-1){1'b0}}, pop_ok};
        end
    end

    assign count = count_q;
    // Head is a register selected by a registered pointer: no path from pop/ready.
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/led_band_reader.sv
// Purpose: reads a burst of len bytes from start_addr out of the LED band memory and streams them.
// Latency: start accepted at t -> mem_read at t+1 -> first out_valid at t+3; 1 byte/cycle sustained.
// Backpressure: out_ready stalls the stream; reads are credit-limited so the 4-entry FIFO never overflows.
// Ports: start/start_addr/len request a burst (sampled in IDLE only); busy/done report progress;
//        mem_read/mem_addr/mem_data form a 1-cycle-latency read port; out_data/out_valid/out_ready
//        form the output stream.
module led_band_reader
    import led_band_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int LEN_WIDTH  = LEN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [LEN_WIDTH:0] CNT_ONE = (LEN_WIDTH+1)'(1);

    rd_state_t             state_q;
    rd_state_t             state_d;
    // One extra bit so the largest legal len never wraps the issue counter.
    logic [LEN_WIDTH:0]    len_q;
    logic [LEN_WIDTH:0]    issued_q;
    logic [ADDR_WIDTH-1:0] next_addr_q;   // address of the next read to issue
    logic [ADDR_WIDTH-1:0] last_addr_q;   // address of the most recent read issued
    logic                  inflight_q;    // a read was issued last cycle; its data is on mem_data now
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  credit_ok;
    logic                  issue;
    logic                  pop;

    // Credit uses only registered occupancy; a pop this cycle is deliberately not counted.
    assign credit_ok = ({1'b0, fifo_count} + {{FIFO_CNT_W{1'b0}}, inflight_q})
                       < (FIFO_CNT_W+1)'(FIFO_DEPTH);
    assign issue     = (state_q == ST_READ) && (issued_q < len_q) && credit_ok;

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? ST_DRAIN : ST_READ;
                end
            end
            ST_READ: begin
                if (issue && ((issued_q + CNT_ONE) == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((fifo_count == '0) && !inflight_q) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            next_addr_q <= '0;
            last_addr_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if ((state_q == ST_IDLE) && start) begin
                len_q       <= {1'b0, len};
                issued_q    <= '0;
                next_addr_q <= start_addr;
            end
            if (issue) begin
                issued_q    <= issued_q + CNT_ONE;
                next_addr_q <= next_addr_q + ADDR_WIDTH'(1);   // wraps modulo 2^ADDR_WIDTH
                last_addr_q <= next_addr_q;
            end
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign mem_read = issue;
    // Show the live address while reading, otherwise hold the last one issued.
    assign mem_addr = issue ? next_addr_q : last_addr_q;

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;

    // Reset clears inflight_q, so data returning right after a reset is never pushed.
    led_byte_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (mem_data),
        .pop       (pop),
        .count     (fifo_count),
        .head      (out_data)
    );

endmodule

// File: tb/tb_led_band_reader.sv
// Self-checking bench for led_band_reader with a random-content memory and a burst-level reference.
module tb_led_band_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [14:0] start_addr;
    logic [14:0] len;
    logic        busy;
    logic        done;
    logic        mem_read;
    logic [14:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    led_band_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: random contents, data one cycle after the read, junk otherwise.
    logic [7:0] mem [0:32767];
    always @(posedge clk) mem_data <= mem_read ? mem[mem_addr] : 8'($urandom);

    // Monitor: logs activity in the middle of each cycle.
    logic [14:0] addr_log [$];
    int          addr_cyc [$];
    logic [7:0]  got_log  [$];
    int          got_cyc  [$];
    int          done_cnt = 0;
    int          valid_cnt = 0;
    int          stall_viol = 0;
    logic        busy_at_done = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (mem_read) begin
                addr_log.push_back(mem_addr);
                addr_cyc.push_back(cyc);
            end
            if (out_valid) valid_cnt++;
            if (out_valid && out_ready) begin
                got_log.push_back(out_data);
                got_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                busy_at_done = busy;
            end
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stall_viol++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    function automatic logic ready_val(input int mode, input int k);
        logic r;
        r = 1'b1;
        if (mode == 1) r = 1'($urandom);
        if (mode == 2) begin
            if ((k % 8) < 4) r = ((k % 4) == 0) || ((k % 4) == 3);
            else             r = 1'($urandom);
        end
        return r;
    endfunction

    // Drives one burst and waits (bounded) for done. Optionally pokes start mid-burst.
    task automatic run_burst(input logic [14:0] a, input logic [14:0] n, input int mode,
                             input bit poke, output int t_acc, output int t_done, output bit to);
        start_addr = a;
        len        = n;
        start      = 1'b1;
        t_acc      = cyc;
        t_done     = -1;
        to         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 40000; k++) begin
            out_ready = ready_val(mode, k);
            if (poke && k == 2) begin
                start      = 1'b1;
                start_addr = 15'($urandom);
                len        = 15'($urandom_range(1, 30));
            end
            if (poke && k == 3) start = 1'b0;
            @(negedge clk);
            if (done) begin
                t_done = cyc;
                to     = 1'b0;
            end
            @(posedge clk); #1;
            if (!to) break;
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if ({busy, done, mem_read, out_valid} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_ctrl: busy/done/rd/vld=%b expected 0000", {busy, done, mem_read, out_valid}); end
        n_checks++; if (mem_addr !== 15'h0) begin n_fail++;
            $display("FAIL reset_addr: got %h expected 0000", mem_addr); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++;
            $display("FAIL reset_data: got %h expected 00", out_data); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({busy, done, mem_read, out_valid} !== 4'b0000) begin n_fail++;
            $display("FAIL idle_ctrl: busy/done/rd/vld=%b expected 0000", {busy, done, mem_read, out_valid}); end
    endtask

    task automatic test_basic();
        int ga = got_log.size(), aa = addr_log.size(), dc = done_cnt, ta, td;
        bit to;
        run_burst(15'h0010, 15'd4, 0, 1'b0, ta, td, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: no done seen"); end
        n_checks++; if (addr_log.size() - aa !== 4) begin n_fail++;
            $display("FAIL basic_nreads: got %0d expected 4", addr_log.size() - aa); end
        n_checks++; if (got_log.size() - ga !== 4) begin n_fail++;
            $display("FAIL basic_nbytes: got %0d expected 4", got_log.size() - ga); end
        for (int i = 0; i < 4 && aa + i < addr_log.size(); i++) begin
            n_checks++; if (addr_log[aa+i] !== 15'h10 + 15'(i) || addr_cyc[aa+i] !== ta + 1 + i) begin n_fail++;
                $display("FAIL basic_addr[%0d]: got %h@%0d expected %h@%0d", i, addr_log[aa+i], addr_cyc[aa+i], 15'h10 + 15'(i), ta + 1 + i); end
        end
        for (int i = 0; i < 4 && ga + i < got_log.size(); i++) begin
            n_checks++; if (got_log[ga+i] !== mem[15'h10 + 15'(i)] || got_cyc[ga+i] !== ta + 3 + i) begin n_fail++;
                $display("FAIL basic_byte[%0d]: got %h@%0d expected %h@%0d", i, got_log[ga+i], got_cyc[ga+i], mem[15'h10 + 15'(i)], ta + 3 + i); end
        end
        n_checks++; if (done_cnt - dc !== 1) begin n_fail++;
            $display("FAIL basic_done: got %0d pulses expected 1", done_cnt - dc); end
        n_checks++; if (busy_at_done !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL basic_busy: at done %b after %b expected 1 0", busy_at_done, busy); end
    endtask

    task automatic test_len_zero();
        int ga = got_log.size(), aa = addr_log.size(), vc = valid_cnt, dc = done_cnt, ta, td;
        bit to;
        run_burst(15'($urandom), 15'd0, 1, 1'b0, ta, td, to);
        n_checks++; if (to || td - ta > 2 || td - ta < 1) begin n_fail++;
            $display("FAIL zero_done_lat: got %0d cycles (timeout %b) expected 1..2", td - ta, to); end
        n_checks++; if (addr_log.size() !== aa) begin n_fail++;
            $display("FAIL zero_reads: got %0d reads expected 0", addr_log.size() - aa); end
        n_checks++; if (valid_cnt !== vc || got_log.size() !== ga) begin n_fail++;
            $display("FAIL zero_valid: got %0d valid cycles expected 0", valid_cnt - vc); end
        n_checks++; if (done_cnt - dc !== 1 || busy_at_done !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL zero_busy: pulses %0d busy@done %b busy after %b expected 1 1 0", done_cnt - dc, busy_at_done, busy); end
    endtask

    task automatic test_wrap();
        int ga = got_log.size(), aa = addr_log.size(), ta, td;
        bit to;
        logic [14:0] ea;
        run_burst(15'h7FFE, 15'd4, 0, 1'b0, ta, td, to);
        n_checks++; if (to || got_log.size() - ga !== 4 || addr_log.size() - aa !== 4) begin n_fail++;
            $display("FAIL wrap_count: bytes %0d reads %0d timeout %b expected 4 4 0", got_log.size() - ga, addr_log.size() - aa, to); end
        for (int i = 0; i < 4 && ga + i < got_log.size() && aa + i < addr_log.size(); i++) begin
            ea = 15'h7FFE + 15'(i);
            n_checks++; if (addr_log[aa+i] !== ea || got_log[ga+i] !== mem[ea]) begin n_fail++;
                $display("FAIL wrap[%0d]: addr %h data %h expected %h %h", i, addr_log[aa+i], got_log[ga+i], ea, mem[ea]); end
        end
    endtask

    task automatic test_stall();
        int ga = got_log.size(), sv = stall_viol, dc = done_cnt, ta, td;
        bit to;
        logic [14:0] a = 15'($urandom);
        logic [14:0] ea;
        run_burst(a, 15'd16, 2, 1'b0, ta, td, to);
        n_checks++; if (to || got_log.size() - ga !== 16 || done_cnt - dc !== 1) begin n_fail++;
            $display("FAIL stall_count: bytes %0d done %0d timeout %b expected 16 1 0", got_log.size() - ga, done_cnt - dc, to); end
        for (int i = 0; i < 16 && ga + i < got_log.size(); i++) begin
            ea = a + 15'(i);
            n_checks++; if (got_log[ga+i] !== mem[ea]) begin n_fail++;
                $display("FAIL stall_byte[%0d]: got %h expected %h", i, got_log[ga+i], mem[ea]); end
        end
        n_checks++; if (stall_viol !== sv) begin n_fail++;
            $display("FAIL stall_hold: got %0d unstable stall cycles expected 0", stall_viol - sv); end
    endtask

    task automatic test_restart();
        int ga = got_log.size(), aa = addr_log.size(), dc = done_cnt, ta, td;
        bit to;
        logic [14:0] a = 15'($urandom);
        logic [14:0] ea;
        run_burst(a, 15'd12, 1, 1'b1, ta, td, to);
        n_checks++; if (to || got_log.size() - ga !== 12 || addr_log.size() - aa !== 12 || done_cnt - dc !== 1) begin n_fail++;
            $display("FAIL restart_count: bytes %0d reads %0d done %0d expected 12 12 1", got_log.size() - ga, addr_log.size() - aa, done_cnt - dc); end
        for (int i = 0; i < 12 && ga + i < got_log.size(); i++) begin
            ea = a + 15'(i);
            n_checks++; if (got_log[ga+i] !== mem[ea]) begin n_fail++;
                $display("FAIL restart_byte[%0d]: got %h expected %h", i, got_log[ga+i], mem[ea]); end
        end
    endtask

    task automatic test_reset_mid();
        int ga = got_log.size(), dc, vc, ta, td;
        bit to, hit = 1'b0;
        logic [14:0] a = 15'($urandom);
        logic [14:0] ea;
        start_addr = a; len = 15'd10; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (got_log.size() >= ga + 3) begin hit = 1'b1; break; end
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL rstmid_third: third byte never seen"); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({busy, done, mem_read, out_valid} !== 4'b0000 || mem_addr !== 15'h0 || out_data !== 8'h00) begin n_fail++;
            $display("FAIL rstmid_outputs: ctrl %b addr %h data %h expected 0000 0000 00", {busy, done, mem_read, out_valid}, mem_addr, out_data); end
        rst = 1'b0;
        dc = done_cnt; vc = valid_cnt;
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (done_cnt !== dc || valid_cnt !== vc) begin n_fail++;
            $display("FAIL rstmid_quiet: done %0d valid %0d expected 0 0", done_cnt - dc, valid_cnt - vc); end
        ga = got_log.size(); dc = done_cnt;
        a = 15'($urandom);
        run_burst(a, 15'd6, 1, 1'b0, ta, td, to);
        n_checks++; if (to || got_log.size() - ga !== 6 || done_cnt - dc !== 1) begin n_fail++;
            $display("FAIL rstmid_after: bytes %0d done %0d expected 6 1", got_log.size() - ga, done_cnt - dc); end
        for (int i = 0; i < 6 && ga + i < got_log.size(); i++) begin
            ea = a + 15'(i);
            n_checks++; if (got_log[ga+i] !== mem[ea]) begin n_fail++;
                $display("FAIL rstmid_byte[%0d]: got %h expected %h", i, got_log[ga+i], mem[ea]); end
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            int ga = got_log.size(), dc = done_cnt, ta, td;
            bit to;
            logic [14:0] a = 15'($urandom);
            logic [14:0] n = 15'($urandom_range(1, 40));
            logic [14:0] ea;
            run_burst(a, n, $urandom_range(0, 1), 1'b0, ta, td, to);
            n_checks++; if (to || got_log.size() - ga !== int'(n) || done_cnt - dc !== 1) begin n_fail++;
                $display("FAIL rand%0d_count: bytes %0d done %0d expected %0d 1", b, got_log.size() - ga, done_cnt - dc, n); end
            for (int i = 0; i < int'(n) && ga + i < got_log.size(); i++) begin
                ea = a + 15'(i);
                n_checks++; if (got_log[ga+i] !== mem[ea]) begin n_fail++;
                    $display("FAIL rand%0d_byte[%0d]: got %h expected %h", b, i, got_log[ga+i], mem[ea]); end
            end
        end
    endtask

    task automatic test_max_len();
        int ga = got_log.size(), dc = done_cnt, ta, td, bad = 0;
        bit to;
        logic [14:0] a = 15'($urandom);
        logic [14:0] ea;
        run_burst(a, 15'h7FFF, 0, 1'b0, ta, td, to);
        n_checks++; if (to || got_log.size() - ga !== 32767 || done_cnt - dc !== 1) begin n_fail++;
            $display("FAIL maxlen_count: bytes %0d done %0d timeout %b expected 32767 1 0", got_log.size() - ga, done_cnt - dc, to); end
        for (int i = 0; i < 32767 && ga + i < got_log.size(); i++) begin
            ea = a + 15'(i);
            if (got_log[ga+i] !== mem[ea]) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++;
            $display("FAIL maxlen_data: got %0d wrong bytes expected 0", bad); end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_stall();
        test_restart();
        test_reset_mid();
        test_random();
        test_max_len();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
